// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the key-scheduling and PRGA/XOR stages.
package rc4_pkg;
  localparam int DATA_W    = 4;
  localparam int N_ENTRIES = 16;

  typedef logic [DATA_W-1:0] nibble_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_JSTEP,
    ST_SWAP,
    ST_EMIT,
    ST_DONE
  } state_t;
endpackage

// File: rtl/rc4_sbox_regfile.sv
// 16x4 RC4 S-box: identity on reset, three async read ports, a load port and
// a dual-write swap port (swap has priority; the FSM keeps them exclusive).
module rc4_sbox_regfile #(
  parameter int DATA_W    = 4,
  parameter int N_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_en,
  input  logic [DATA_W-1:0] idx_i,
  input  logic [DATA_W-1:0] idx_j,
  input  logic [DATA_W-1:0] idx_t,
  output logic [DATA_W-1:0] s_i,
  output logic [DATA_W-1:0] s_j,
  output logic [DATA_W-1:0] s_t
);
  import rc4_pkg::*;

  logic [DATA_W-1:0] mem [N_ENTRIES];

  assign s_i = mem[idx_i];
  assign s_j = mem[idx_j];
  assign s_t = mem[idx_t];

  // When idx_i == idx_j both writes carry the same value, so the entry is unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_ENTRIES; k++) mem[k] <= DATA_W'(k);
    end else if (swap_en) begin
      mem[idx_i] <= s_j;
      mem[idx_j] <= s_i;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end
endmodule

// File: rtl/rc4_prga_xor.sv
// Nibble-wide RC4 PRGA with plaintext XOR: one nibble per FETCH/JSTEP/SWAP/EMIT
// pass, valid/ready on both sides, done pulse after MSG_LEN nibbles.
module rc4_prga_xor #(
  parameter int N_ENTRIES = 16,
  parameter int DATA_W    = 4,
  parameter int MSG_LEN   = 16
) (
  input  logic              clk,
  input  logic              reset_1,
  input  logic              s_wr_en,
  input  logic [DATA_W-1:0] s_wr_addr,
  input  logic [DATA_W-1:0] s_wr_data,
  input  logic              start,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              busy,
  output logic              done
);
  import rc4_pkg::*;

  localparam logic [7:0] LAST_CNT = 8'(MSG_LEN - 1);

  state_t            state, state_next;
  logic [DATA_W-1:0] i, j, din_q;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] s_i, s_j, s_t, t;

  assign t = s_i + s_j;

  rc4_sbox_regfile #(
    .DATA_W   (DATA_W),
    .N_ENTRIES(N_ENTRIES)
  ) u_sbox (
    .clk    (clk),
    .rst    (reset_1),
    .wr_en  (s_wr_en && (state == ST_IDLE)),
    .wr_addr(s_wr_addr),
    .wr_data(s_wr_data),
    .swap_en(state == ST_SWAP),
    .idx_i  (i),
    .idx_j  (j),
    .idx_t  (t),
    .s_i    (s_i),
    .s_j    (s_j),
    .s_t    (s_t)
  );

  always_ff @(posedge clk) begin
    if (reset_1) begin
      state <= ST_IDLE;
      i     <= '0;
      j     <= '0;
      cnt   <= '0;
      din_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: if (start) begin
          i   <= '0;
          j   <= '0;
          cnt <= '0;
        end
        ST_FETCH: if (din_valid) begin
          din_q <= din;
          i     <= i + 1'b1;
        end
        ST_JSTEP: j <= j + s_i;
        ST_EMIT:  if (dout_ready) cnt <= cnt + 8'd1;
        default: ;
      endcase
    end
  end

  // dout is forced to zero outside EMIT so nothing partial leaks downstream.
  always_comb begin
    state_next = state;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    done       = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        din_ready = 1'b1;
        if (din_valid) state_next = ST_JSTEP;
      end
      ST_JSTEP: state_next = ST_SWAP;
      ST_SWAP:  state_next = ST_EMIT;
      ST_EMIT: begin
        dout_valid = 1'b1;
        dout       = din_q ^ s_t;
        if (dout_ready) state_next = (cnt == LAST_CNT) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_rc4_prga_xor.sv
// Directed bench for rc4_prga_xor: hand-computed keystreams plus a small RC4 model.
module tb_rc4_prga_xor;
  logic       clk = 1'b0;
  logic       reset_1 = 1'b1;
  logic       s_wr_en = 1'b0;
  logic [3:0] s_wr_addr = '0;
  logic [3:0] s_wr_data = '0;
  logic       start = 1'b0;
  logic [3:0] din = '0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [3:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  rc4_prga_xor #(.N_ENTRIES(16), .DATA_W(4), .MSG_LEN(16)) dut (
    .clk(clk), .reset_1(reset_1), .s_wr_en(s_wr_en), .s_wr_addr(s_wr_addr),
    .s_wr_data(s_wr_data), .start(start), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_1 = 1'b1; start = 1'b0; s_wr_en = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    tick();
    tick();
    reset_1 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives one nibble through the handshake; reports dout, latency and stability.
  task automatic send_nibble(input logic [3:0] nib, input int in_stall, input int out_stall,
                             output logic [3:0] got, output int lat, output bit stable,
                             output bit ok);
    int n;
    ok = 1'b1; stable = 1'b1; lat = 0; got = '0;
    din_valid = 1'b0;
    repeat (in_stall) tick();
    din = nib; din_valid = 1'b1;
    n = 0;
    while (!din_ready && n < 20) begin tick(); n++; end
    if (!din_ready) ok = 1'b0;
    tick();
    din_valid = 1'b0;
    lat = 1;
    while (!dout_valid && lat < 20) begin tick(); lat++; end
    if (!dout_valid) ok = 1'b0;
    got = dout;
    repeat (out_stall) begin
      tick();
      if (dout !== got || dout_valid !== 1'b1) stable = 1'b0;
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
  endtask

  task automatic test_reset();
    bit ident;
    apply_reset();
    checks++;
    if ({din_ready, dout_valid, busy, done} !== 4'b0000 || dout !== 4'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b vld=%b busy=%b done=%b dout=%h, expected all 0",
               din_ready, dout_valid, busy, done, dout);
    end
    ident = 1'b1;
    for (int k = 0; k < 16; k++) if (dut.u_sbox.mem[k] !== 4'(k)) ident = 1'b0;
    checks++;
    if (!ident) begin errors++; $display("FAIL reset_sbox: got non-identity, expected S[k]=k"); end
  endtask

  task automatic test_identity(input string tag, input logic [3:0] d0, input logic [3:0] d1,
                               input logic [3:0] d2, input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input int in_stall, input int out_stall);
    logic [3:0] din_v [3];
    logic [3:0] exp_v [3];
    logic [3:0] got;
    int lat;
    bit stable, ok;
    din_v[0] = d0; din_v[1] = d1; din_v[2] = d2;
    exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
    apply_reset();
    pulse_start();
    for (int n = 0; n < 3; n++) begin
      send_nibble(din_v[n], in_stall, out_stall, got, lat, stable, ok);
      checks++;
      if (!ok || got !== exp_v[n]) begin
        errors++;
        $display("FAIL %s_dout[%0d]: got %h (ok=%b), expected %h", tag, n, got, ok, exp_v[n]);
      end
      checks++;
      if (lat !== 3) begin
        errors++;
        $display("FAIL %s_latency[%0d]: got %0d cycles, expected 3", tag, n, lat);
      end
      checks++;
      if (!stable) begin
        errors++;
        $display("FAIL %s_stable[%0d]: dout changed while stalled", tag, n);
      end
    end
    checks++;
    if (dut.u_sbox.mem[2] !== 4'h3 || dut.u_sbox.mem[3] !== 4'h5 || dut.u_sbox.mem[5] !== 4'h2) begin
      errors++;
      $display("FAIL %s_sbox: got S2=%h S3=%h S5=%h, expected 3 5 2", tag,
               dut.u_sbox.mem[2], dut.u_sbox.mem[3], dut.u_sbox.mem[5]);
    end
  endtask

  task automatic test_reversed_full();
    logic [3:0] ms [16];
    logic [3:0] mi, mj, tmp, dv, expv, got;
    int lat;
    bit stable, ok, bad;
    apply_reset();
    for (int k = 0; k < 16; k++) begin
      s_wr_en = 1'b1; s_wr_addr = 4'(k); s_wr_data = 4'(15 - k);
      ms[k] = 4'(15 - k);
      tick();
    end
    s_wr_en = 1'b0;
    pulse_start();
    mi = '0; mj = '0; bad = 1'b0;
    for (int n = 0; n < 16; n++) begin
      dv = 4'((n * 7 + 3) & 15);
      mi = mi + 4'd1;
      mj = mj + ms[mi];
      tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
      expv = dv ^ ms[4'(ms[mi] + ms[mj])];
      send_nibble(dv, 0, 0, got, lat, stable, ok);
      checks++;
      if (!ok || got !== expv) begin
        errors++;
        $display("FAIL rev_dout[%0d]: got %h (ok=%b), expected %h", n, got, ok, expv);
      end
      if (n < 15 && done !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL rev_early_done: got done=1 before last nibble, expected 0"); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rev_done_pulse: got done=%b busy=%b, expected 1 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rev_after_done: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset_in_swap();
    logic [3:0] got;
    int lat;
    bit stable, ok, ident;
    apply_reset();
    pulse_start();
    send_nibble(4'h0, 0, 0, got, lat, stable, ok);
    din = 4'h0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL swap_precond: got busy=%b vld=%b, expected 1 0", busy, dout_valid);
    end
    reset_1 = 1'b1;
    tick();
    reset_1 = 1'b0;
    checks++;
    if ({din_ready, dout_valid, busy, done} !== 4'b0000 || dout !== 4'h0) begin
      errors++;
      $display("FAIL abort_outputs: got rdy=%b vld=%b busy=%b done=%b dout=%h, expected all 0",
               din_ready, dout_valid, busy, done, dout);
    end
    ident = 1'b1;
    for (int k = 0; k < 16; k++) if (dut.u_sbox.mem[k] !== 4'(k)) ident = 1'b0;
    checks++;
    if (!ident) begin errors++; $display("FAIL abort_sbox: got non-identity, expected S[k]=k"); end
    pulse_start();
    for (int n = 0; n < 3; n++) begin
      logic [3:0] expv;
      expv = (n == 0) ? 4'h2 : (n == 1) ? 4'h5 : 4'h7;
      send_nibble(4'h0, 0, 0, got, lat, stable, ok);
      checks++;
      if (!ok || got !== expv) begin
        errors++;
        $display("FAIL abort_restart[%0d]: got %h (ok=%b), expected %h", n, got, ok, expv);
      end
    end
  endtask

  task automatic test_ignored_and_combined();
    logic [3:0] got;
    int lat;
    bit stable, ok;
    apply_reset();
    pulse_start();
    din = 4'h0; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick();
    tick();
    start = 1'b1; s_wr_en = 1'b1; s_wr_addr = 4'h7; s_wr_data = 4'h0;
    tick();
    start = 1'b0; s_wr_en = 1'b0;
    checks++;
    if (dout_valid !== 1'b1 || dout !== 4'h2 || dut.u_sbox.mem[7] !== 4'h7) begin
      errors++;
      $display("FAIL emit_ignore: got vld=%b dout=%h S7=%h, expected 1 2 7",
               dout_valid, dout, dut.u_sbox.mem[7]);
    end
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    apply_reset();
    start = 1'b1; s_wr_en = 1'b1; s_wr_addr = 4'h2; s_wr_data = 4'h9;
    tick();
    start = 1'b0; s_wr_en = 1'b0;
    checks++;
    if (dut.u_sbox.mem[2] !== 4'h9 || busy !== 1'b1 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL combo_start: got S2=%h busy=%b rdy=%b, expected 9 1 1",
               dut.u_sbox.mem[2], busy, din_ready);
    end
    for (int n = 0; n < 3; n++) begin
      logic [3:0] expv;
      expv = (n == 0) ? 4'h9 : (n == 1) ? 4'h3 : 4'h0;
      send_nibble(4'h0, 0, 0, got, lat, stable, ok);
      checks++;
      if (!ok || got !== expv) begin
        errors++;
        $display("FAIL combo_dout[%0d]: got %h (ok=%b), expected %h", n, got, ok, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_identity("id0", 4'h0, 4'h0, 4'h0, 4'h2, 4'h5, 4'h7, 0, 0);
    test_identity("idfa", 4'hF, 4'hA, 4'h0, 4'hD, 4'hF, 4'h7, 0, 0);
    test_reversed_full();
    test_identity("stall", 4'h0, 4'h0, 4'h0, 4'h2, 4'h5, 4'h7, 4, 5);
    test_reset_in_swap();
    test_ignored_and_combined();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
